// File: rtl/write_once_reg_programmer.sv
// Programs one write-once register: checks its lock bit, strobes the write, waits for
// the target to settle, then reports the readback and a status code.
module write_once_reg_programmer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             ip_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_lock,
  output logic             write,
  output logic [WIDTH-1:0] Data_in,
  input  logic [WIDTH-1:0] Data_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [WIDTH-1:0] rb_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WR   = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_LOCKED   = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] w_din_next;
  logic [1:0]       r_status;
  logic [1:0]       w_status_next;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] w_rb_next;
  logic             r_write;
  logic             r_done;
  logic             r_busy;
  logic             r_cmd_ready;
  logic             w_accept;

  assign w_accept = cmd_valid & r_cmd_ready;

  // Next-state, counter and result-capture logic
  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_din_next    = r_din;
    w_status_next = r_status;
    w_rb_next     = r_rb;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_din_next = {cmd_data[WIDTH-1:1], cmd_lock};
          w_cnt_next = 4'd0;
          w_next     = S_PRE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_PRE: begin
        if (r_cnt == LAST_CNT) begin
          // A locked target is never strobed; report what it currently holds.
          if (Data_out[0]) begin
            w_rb_next     = Data_out;
            w_status_next = ST_LOCKED;
            w_next        = S_DONE;
          end else begin
            w_next = S_WR;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_WR: begin
        w_cnt_next = 4'd0;
        w_next     = S_POST;
      end
      S_POST: begin
        if (r_cnt == LAST_CNT) begin
          w_rb_next     = Data_out;
          w_status_next = (Data_out == r_din) ? ST_OK : ST_MISMATCH;
          w_next        = S_DONE;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge Clk or posedge ip_reset) begin
    if (ip_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_din       <= '0;
      r_status    <= ST_OK;
      r_rb        <= '0;
      r_write     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_din       <= w_din_next;
      r_status    <= w_status_next;
      r_rb        <= w_rb_next;
      r_write     <= (w_next == S_WR);
      r_done      <= (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE);
      r_cmd_ready <= (w_next == S_IDLE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign write     = r_write;
  assign Data_in   = r_din;
  assign busy      = r_busy;
  assign done      = r_done;
  assign status    = r_status;
  assign rb_data   = r_rb;

endmodule

// File: tb/tb_write_once_reg_programmer.sv
// Bench for write_once_reg_programmer: a behavioural write-once target plus a
// command-level model of what each command must report.
module tb_write_once_reg_programmer;

  localparam int W = 16;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         ip_reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_data;
  logic         cmd_lock;
  logic         write;
  logic [W-1:0] Data_in;
  logic [W-1:0] Data_out;
  logic         busy;
  logic         done;
  logic [1:0]   status;
  logic [W-1:0] rb_data;

  int total = 0;
  int bad   = 0;

  // Target register model with optional stuck-at-0 readback bits
  logic [W-1:1] t_data;
  logic         t_lock;
  logic         t_pend;
  logic         t_wr_d;
  logic         tgt_rst;
  logic [W-1:0] stuck_mask;

  // Command-level model of the target's contents
  logic [W-1:0] m_val;
  logic         m_locked;

  write_once_reg_programmer #(.WIDTH(W), .SETTLE(S)) dut (
    .Clk(Clk), .ip_reset(ip_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_lock(cmd_lock), .write(write), .Data_in(Data_in),
    .Data_out(Data_out), .busy(busy), .done(done), .status(status), .rb_data(rb_data)
  );

  always #5 Clk = ~Clk;

  // Data bits follow the strobe by one edge; the lock bit follows the falling strobe by one edge
  always @(posedge Clk) begin
    if (tgt_rst) begin
      t_data <= '0;
      t_lock <= 1'b0;
      t_pend <= 1'b0;
      t_wr_d <= 1'b0;
    end else begin
      t_wr_d <= write;
      if (write && !t_lock) begin
        t_data <= Data_in[W-1:1];
        t_pend <= Data_in[0];
      end
      if (t_wr_d && !write && !t_lock) t_lock <= t_pend;
    end
  end

  assign Data_out = {t_data, t_lock} & ~stuck_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_target();
    @(negedge Clk);
    tgt_rst = 1'b1;
    @(negedge Clk);
    tgt_rst  = 1'b0;
    m_val    = '0;
    m_locked = 1'b0;
  endtask

  task automatic run_cmd(input logic [W-1:0] d, input logic lk);
    logic [W-1:0] exp_din;
    logic [W-1:0] exp_rb;
    logic [1:0]   exp_st;
    int           exp_done, exp_wr_cyc, exp_wr_cnt;
    int           done_cyc, wr_cyc, wr_cnt;
    exp_din = {d[W-1:1], lk};
    if (m_locked) begin
      exp_rb     = m_val & ~stuck_mask;
      exp_st     = 2'b01;
      exp_done   = S + 1;
      exp_wr_cyc = -1;
      exp_wr_cnt = 0;
    end else begin
      m_val      = exp_din;
      m_locked   = lk;
      exp_rb     = m_val & ~stuck_mask;
      exp_st     = (exp_rb == exp_din) ? 2'b00 : 2'b10;
      exp_done   = 2 * S + 2;
      exp_wr_cyc = S + 1;
      exp_wr_cnt = 1;
    end
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_lock  = lk;
    chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge Clk);
    cmd_valid = 1'b0;
    cmd_data  = W'($urandom);
    done_cyc  = -1;
    wr_cyc    = -1;
    wr_cnt    = 0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      if (k > 1) @(negedge Clk);
      if (write) begin
        wr_cnt++;
        wr_cyc = k;
      end
      if (done) done_cyc = k;
      if (k == 1) begin
        chk("din_accept", {16'd0, Data_in}, {16'd0, exp_din});
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("ready_run", {31'd0, cmd_ready}, 32'd0);
      end
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("write_count", wr_cnt, exp_wr_cnt);
    chk("write_cycle", wr_cyc, exp_wr_cyc);
    chk("status", {30'd0, status}, {30'd0, exp_st});
    chk("rb_data", {16'd0, rb_data}, {16'd0, exp_rb});
    chk("din_hold", {16'd0, Data_in}, {16'd0, exp_din});
    @(negedge Clk);
    chk("done_width", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int acc;
    int drain;
    logic prev_done;
    logic prev_acc;
    logic [W-1:0] acc_din;

    ip_reset   = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_lock   = 1'b0;
    tgt_rst    = 1'b1;
    stuck_mask = '0;
    m_val      = '0;
    m_locked   = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_rb", {16'd0, rb_data}, 32'd0);
    chk("rst_din", {16'd0, Data_in}, 32'd0);
    ip_reset = 1'b0;
    tgt_rst  = 1'b0;
    @(negedge Clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Fresh write, locking write, refused write
    run_cmd(16'hA5A4, 1'b0);
    chk("t1_rb", {16'd0, rb_data}, 32'h0000A5A4);
    run_cmd(16'h1235, 1'b1);
    chk("t2_rb", {16'd0, rb_data}, 32'h00001235);
    run_cmd(16'hFFFE, 1'b0);
    chk("t3_status", {30'd0, status}, 32'd1);
    chk("t3_rb", {16'd0, rb_data}, 32'h00001235);

    // Readback bit 7 stuck low
    reset_target();
    stuck_mask = 16'h0080;
    run_cmd(16'h0080, 1'b0);
    chk("t4_status", {30'd0, status}, 32'd2);
    chk("t4_rb", {16'd0, rb_data}, 32'd0);
    stuck_mask = '0;

    // Reset during POST
    reset_target();
    @(negedge Clk);
    cmd_valid = 1'b1;
    cmd_data  = 16'h3C3C;
    cmd_lock  = 1'b0;
    @(negedge Clk);
    cmd_valid = 1'b0;
    repeat (S + 1) @(negedge Clk);
    chk("t5_busy_post", {31'd0, busy}, 32'd1);
    m_val    = 16'h3C3C;
    ip_reset = 1'b1;
    #1;
    chk("t5_write", {31'd0, write}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge Clk);
    chk("t5_done_hold", {31'd0, done}, 32'd0);
    ip_reset = 1'b0;
    run_cmd(16'h5A5A, 1'b0);

    // cmd_valid held high across several commands
    reset_target();
    acc       = 0;
    prev_done = 1'b0;
    prev_acc  = 1'b0;
    acc_din   = '0;
    cmd_lock  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (prev_acc) begin
        chk("t6_busy_after_acc", {31'd0, busy}, 32'd1);
        chk("t6_din", {16'd0, Data_in}, {16'd0, acc_din});
      end
      chk("t6_done_width", {31'd0, done & prev_done}, 32'd0);
      chk("t6_ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
      prev_done = done;
      cmd_valid = 1'b1;
      cmd_data  = W'($urandom);
      prev_acc  = cmd_ready;
      if (cmd_ready) begin
        acc++;
        acc_din = {cmd_data[W-1:1], 1'b0};
      end
    end
    chk("t6_accepts", acc, 3);
    @(negedge Clk);
    cmd_valid = 1'b0;
    drain = 0;
    while (busy && drain < 40) begin
      @(negedge Clk);
      drain++;
    end
    chk("t6_drain", {31'd0, busy}, 32'd0);

    // Randomized commands against the model
    reset_target();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) reset_target();
      if ($urandom_range(0, 3) == 0) stuck_mask = 16'd1 << $urandom_range(1, 15);
      else stuck_mask = '0;
      run_cmd(W'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
